// File: rtl/psm_phase_meter.sv
// Measures REF period and REF->MEAS phase shift (magnitude + sign) in CLK cycles.
// Latency: SYNC_STAGES+1 cycles from REF rising at the pins to oVALID/oERR; no backpressure.
module psm_phase_meter #(
    parameter int BITS_DATA   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iREF,
    input  logic                 iMEAS,
    output logic [BITS_DATA-1:0] oPERIOD,
    output logic [BITS_DATA-1:0] oPHASE_value,
    output logic                 oPHASE_sign,
    output logic                 oVALID,
    output logic                 oLOCK,
    output logic                 oERR
);

    localparam logic [BITS_DATA-1:0] C_ONE = {{(BITS_DATA-1){1'b0}}, 1'b1};
    localparam logic [BITS_DATA-1:0] C_MAX = '1;

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_ref_sync;
    logic [SYNC_STAGES-1:0] r_meas_sync;
    logic                   r_ref_prev;
    logic                   r_meas_prev;
    logic [BITS_DATA-1:0]   r_cnt;
    logic [BITS_DATA-1:0]   r_d;
    logic [1:0]             r_mcnt;
    logic [BITS_DATA-1:0]   r_period;
    logic [BITS_DATA-1:0]   r_phase_val;
    logic                   r_phase_sign;
    logic                   r_valid;
    logic                   r_lock;
    logic                   r_err;

    logic                   w_ref_edge;
    logic                   w_meas_edge;
    logic                   w_cnt_sat;
    logic [BITS_DATA:0]     w_d2;
    logic [BITS_DATA:0]     w_p_ext;
    logic                   w_lag;
    logic [BITS_DATA-1:0]   w_lead_val;

    assign w_ref_edge  = r_ref_sync[SYNC_STAGES-1] & ~r_ref_prev;
    assign w_meas_edge = r_meas_sync[SYNC_STAGES-1] & ~r_meas_prev;
    assign w_cnt_sat   = (r_cnt == C_MAX);

    // One extra bit so 2*d cannot wrap; the exact half-period tie counts as lag.
    assign w_d2       = {r_d, 1'b0};
    assign w_p_ext    = {1'b0, r_cnt};
    assign w_lag      = (w_d2 <= w_p_ext);
    assign w_lead_val = r_cnt - r_d;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ref_sync  <= '0;
            r_meas_sync <= '0;
            r_ref_prev  <= 1'b0;
            r_meas_prev <= 1'b0;
        end else begin
            r_ref_sync  <= {r_ref_sync[SYNC_STAGES-2:0], iREF};
            r_meas_sync <= {r_meas_sync[SYNC_STAGES-2:0], iMEAS};
            r_ref_prev  <= r_ref_sync[SYNC_STAGES-1];
            r_meas_prev <= r_meas_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_ref_edge) w_state_nxt = S_MEASURE;
            S_MEASURE: if (!w_ref_edge && w_cnt_sat) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt        <= '0;
            r_d          <= '0;
            r_mcnt       <= 2'd0;
            r_period     <= '0;
            r_phase_val  <= '0;
            r_phase_sign <= 1'b0;
            r_valid      <= 1'b0;
            r_lock       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (w_ref_edge) begin
                r_cnt <= C_ONE;
            end else if (!w_cnt_sat) begin
                r_cnt <= r_cnt + C_ONE;
            end

            if (w_ref_edge) begin
                // A MEAS edge coincident with REF opens the new window at d=0.
                r_mcnt <= w_meas_edge ? 2'd1 : 2'd0;
                r_d    <= '0;
                if (r_state == S_MEASURE) begin
                    if (r_mcnt == 2'd1) begin
                        r_period     <= r_cnt;
                        r_phase_val  <= w_lag ? r_d : w_lead_val;
                        r_phase_sign <= ~w_lag;
                        r_valid      <= 1'b1;
                        r_lock       <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end else if (r_state == S_MEASURE) begin
                if (w_cnt_sat) begin
                    r_lock <= 1'b0;
                end else if (w_meas_edge) begin
                    r_d <= r_cnt;
                    if (r_mcnt != 2'd2) r_mcnt <= r_mcnt + 2'd1;
                end
            end
        end
    end

    assign oPERIOD      = r_period;
    assign oPHASE_value = r_phase_val;
    assign oPHASE_sign  = r_phase_sign;
    assign oVALID       = r_valid;
    assign oLOCK        = r_lock;
    assign oERR         = r_err;

endmodule

// File: tb/tb_psm_phase_meter.sv
// Bench for psm_phase_meter: event-level reference model compared every cycle,
// plus literal expectations from hand-worked waveforms.
module tb_psm_phase_meter;

    localparam int BD   = 16;
    localparam int SYNC = 2;
    localparam int SATV = 65535;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREF;
    logic          iMEAS;
    logic [BD-1:0] oPERIOD;
    logic [BD-1:0] oPHASE_value;
    logic          oPHASE_sign;
    logic          oVALID;
    logic          oLOCK;
    logic          oERR;

    always #5 CLK = ~CLK;

    psm_phase_meter #(.BITS_DATA(BD), .SYNC_STAGES(SYNC)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .iREF         (iREF),
        .iMEAS        (iMEAS),
        .oPERIOD      (oPERIOD),
        .oPHASE_value (oPHASE_value),
        .oPHASE_sign  (oPHASE_sign),
        .oVALID       (oVALID),
        .oLOCK        (oLOCK),
        .oERR         (oERR)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // Model: pin samples are seen SYNC cycles late; a window is described by
    // its start cycle and the list of MEAS rise offsets inside it.
    bit rq [0:SYNC];
    bit mq [0:SYNC];
    bit m_rst;
    bit m_armed;
    int m_last;
    int m_nmeas;
    int m_d;
    int m_per, m_val;
    bit m_sgn, m_vld, m_err, m_lock;

    always @(posedge CLK) begin
        bit r_rise, s_rise;
        int p;
        cyc = cyc + 1;
        m_rst = !RST;
        if (!RST) begin
            for (int i = 0; i <= SYNC; i++) begin rq[i] = 0; mq[i] = 0; end
            m_armed = 0; m_last = 0; m_nmeas = 0; m_d = 0;
            m_per = 0; m_val = 0; m_sgn = 0; m_vld = 0; m_err = 0; m_lock = 0;
        end else begin
            r_rise = rq[SYNC-1] && !rq[SYNC];
            s_rise = mq[SYNC-1] && !mq[SYNC];
            m_vld = 0;
            m_err = 0;
            if (r_rise) begin
                if (m_armed) begin
                    p = cyc - m_last;
                    if (m_nmeas == 1) begin
                        m_per = p;
                        if (2 * m_d <= p) begin m_val = m_d; m_sgn = 0; end
                        else begin m_val = p - m_d; m_sgn = 1; end
                        m_vld = 1;
                        m_lock = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                m_armed = 1;
                m_last = cyc;
                m_nmeas = s_rise ? 1 : 0;
                m_d = 0;
            end else if (m_armed && (cyc - m_last >= SATV)) begin
                m_armed = 0;
                m_lock = 0;
            end else if (m_armed && s_rise) begin
                m_d = cyc - m_last;
                m_nmeas++;
            end
            for (int i = SYNC; i > 0; i--) begin rq[i] = rq[i-1]; mq[i] = mq[i-1]; end
            rq[0] = iREF;
            mq[0] = iMEAS;
        end
    end

    int n_vld = 0;
    int n_err = 0;
    int last_vld_cyc = 0;
    int lock_fall_cyc = -1;
    bit lock_q = 0;

    always @(negedge CLK) begin
        if (chk_en) begin
            total++;
            if (oPERIOD !== BD'(m_per) || oPHASE_value !== BD'(m_val) ||
                oPHASE_sign !== m_sgn || oVALID !== m_vld || oLOCK !== m_lock || oERR !== m_err) begin
                bad++;
                $display("FAIL model cyc=%0d dut per=%0d val=%0d sgn=%0d vld=%0d lck=%0d err=%0d want per=%0d val=%0d sgn=%0d vld=%0d lck=%0d err=%0d",
                         cyc, oPERIOD, oPHASE_value, oPHASE_sign, oVALID, oLOCK, oERR,
                         m_per, m_val, m_sgn, m_vld, m_lock, m_err);
            end
            if (oVALID === 1'b1) begin n_vld++; last_vld_cyc = cyc; end
            if (oERR === 1'b1) n_err++;
            if (!m_rst && lock_q && oLOCK === 1'b0) lock_fall_cyc = cyc;
            lock_q = (oLOCK === 1'b1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; iREF = 1'b0; iMEAS = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    // REF: 50% square of period per; MEAS: same wave delayed dly, plus optional glitch.
    task automatic run_wave(input int per, input int dly, input int nper, input int g_at, input int g_len);
        for (int t = 0; t < per * nper; t++) begin
            @(negedge CLK);
            iREF  = (t % per) < (per / 2);
            iMEAS = (t >= dly) && (((t - dly) % per) < (per / 2));
            if (g_len > 0 && t >= g_at && t < g_at + g_len) iMEAS = 1'b1;
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic scen(input string name, input int per, input int dly, input int exp_vld,
                        input int exp_per, input int exp_val, input int exp_sgn);
        int v0;
        do_reset();
        v0 = n_vld;
        run_wave(per, dly, 3, 0, 0);
        check({name, "_nvalid"}, n_vld - v0, exp_vld);
        check({name, "_period"}, oPERIOD, exp_per);
        check({name, "_value"}, oPHASE_value, exp_val);
        check({name, "_sign"}, oPHASE_sign, exp_sgn);
        check({name, "_lock"}, oLOCK, 1);
    endtask

    initial begin
        int v0, e0, per, dly, gl;
        RST = 1'b0; iREF = 1'b0; iMEAS = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1;
        check("rst_period", oPERIOD, 0);
        check("rst_lock", oLOCK, 0);
        check("rst_valid", oVALID, 0);
        RST = 1'b1;

        scen("lag1000", 4000, 1000, 2, 4000, 1000, 0);
        scen("lead100", 400, 300, 2, 400, 100, 1);
        scen("zero", 400, 0, 2, 400, 0, 0);
        scen("tie", 400, 200, 2, 400, 200, 0);

        // Extra MEAS pulse inside the second window rejects that window only.
        do_reset();
        v0 = n_vld; e0 = n_err;
        run_wave(400, 100, 4, 750, 5);
        check("glitch_nvalid", n_vld - v0, 2);
        check("glitch_nerr", n_err - e0, 1);
        check("glitch_period", oPERIOD, 400);
        check("glitch_value", oPHASE_value, 100);

        for (int s = 0; s < 6; s++) begin
            per = $urandom_range(120, 8);
            dly = $urandom_range(per - 1, 0);
            gl  = ($urandom_range(2, 0) == 0) ? 3 : 0;
            run_wave(per, dly, 3, per + per / 4, gl);
        end

        // Reset while locked, mid-window.
        do_reset();
        run_wave(400, 100, 3, 0, 0);
        check("pre_rst_lock", oLOCK, 1);
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_period", oPERIOD, 0);
        check("midrst_value", oPHASE_value, 0);
        check("midrst_lock", oLOCK, 0);
        RST = 1'b1;
        v0 = n_vld;
        run_wave(400, 100, 2, 0, 0);
        check("rearm_nvalid", n_vld - v0, 1);

        // REF stops: lock drops after counter saturation, results hold.
        iREF = 1'b0; iMEAS = 1'b0;
        repeat (65600) @(negedge CLK);
        check("lockloss_delay", lock_fall_cyc - last_vld_cyc, 65535);
        check("lockloss_lock", oLOCK, 0);
        check("lockloss_period", oPERIOD, 400);
        v0 = n_vld;
        run_wave(400, 100, 3, 0, 0);
        check("restart_nvalid", n_vld - v0, 2);
        check("restart_lock", oLOCK, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
